// File: rtl/uart_wb_host.sv
// -----------------------------------------------------------------------------
// uart_wb_host
//
// Wishbone initiator that drives the slave port of a 16550-style UART
// (uart_top). After reset it programs the line format and baud divisor once.
// From then on it polls LSR and moves bytes between two valid/ready byte
// streams and the UART data register (THR on write, RBR on read).
//
// Ports:
//   clk, wb_rst_ni                  clock, asynchronous active-low reset
//   wb_adr_o/wb_dat_o/wb_we_o/
//   wb_stb_o/wb_cyc_o/wb_sel_o      Wishbone request (one byte lane per access)
//   wb_dat_i/wb_ack_i               Wishbone response
//   tx_valid_i/tx_data_i/tx_ready_o bytes to transmit (ready is a one-cycle pulse)
//   rx_valid_o/rx_data_o/rx_ready_i received bytes, held until accepted
//   init_done_o                     configuration sequence finished
//   err_o                           sticky: some access waited ACK_TIMEOUT cycles
//   lsr_o                           last LSR value read
// -----------------------------------------------------------------------------
module uart_wb_host #(
  parameter int unsigned ADDR_W      = 5,
  parameter logic [15:0] DIVISOR     = 16'd2,
  parameter logic [7:0]  LCR_VAL     = 8'h1B,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter int unsigned TX_BURST    = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              wb_rst_ni,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_ack_i,
  input  logic              tx_valid_i,
  input  logic [7:0]        tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [7:0]        rx_data_o,
  input  logic              rx_ready_i,
  output logic              init_done_o,
  output logic              err_o,
  output logic [7:0]        lsr_o
);

  localparam int unsigned BW = $clog2(TX_BURST + 1);
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(0);  // RBR / THR / DL1
  localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(1);  // IER / DL2
  localparam logic [ADDR_W-1:0] A_LCR  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_LSR  = ADDR_W'(5);

  typedef enum logic [2:0] {
    CFG_LCR1, CFG_DL1, CFG_DL2, CFG_LCR2, CFG_IER, POLL, RX_RD, TX_WR
  } state_e;

  state_e            state_q;
  logic              busy_q;      // a bus access is outstanding
  logic [TW-1:0]     wait_q;      // cycles spent waiting for ack
  logic [BW-1:0]     burst_q;     // THR writes left in this THRE window
  logic              thre_q;      // THRE seen in the latest LSR read
  logic [ADDR_W-1:0] wb_adr_q;
  logic [31:0]       wb_dat_q;
  logic              wb_we_q;
  logic              wb_cyc_q;
  logic              wb_stb_q;
  logic [3:0]        wb_sel_q;
  logic              rx_valid_q;
  logic [7:0]        rx_data_q;
  logic              init_done_q;
  logic              err_q;
  logic [7:0]        lsr_q;

  // Access the current state would issue.
  logic [ADDR_W-1:0] acc_adr;
  logic [7:0]        acc_byte;
  logic              acc_we;
  logic [31:0]       acc_dat;
  logic [3:0]        acc_sel;

  always_comb begin
    acc_adr  = A_DATA;
    acc_byte = 8'h00;
    acc_we   = 1'b1;
    case (state_q)
      CFG_LCR1: begin acc_adr = A_LCR;  acc_byte = LCR_VAL | 8'h80; end
      CFG_DL1:  begin acc_adr = A_DATA; acc_byte = DIVISOR[7:0];    end
      CFG_DL2:  begin acc_adr = A_IER;  acc_byte = DIVISOR[15:8];   end
      CFG_LCR2: begin acc_adr = A_LCR;  acc_byte = LCR_VAL & 8'h7F; end
      CFG_IER:  begin acc_adr = A_IER;  acc_byte = IER_VAL;         end
      POLL:     begin acc_adr = A_LSR;  acc_we = 1'b0;              end
      RX_RD:    begin acc_adr = A_DATA; acc_we = 1'b0;              end
      TX_WR:    begin acc_adr = A_DATA; acc_byte = tx_data_i;       end
      default:  ;
    endcase
  end

  // The byte sits on lane a[1:0]; the other lanes stay zero.
  always_comb begin
    acc_dat = 32'h0;
    acc_sel = 4'b0000;
    case (acc_adr[1:0])
      2'd0: begin acc_dat[7:0]   = acc_byte; acc_sel = 4'b0001; end
      2'd1: begin acc_dat[15:8]  = acc_byte; acc_sel = 4'b0010; end
      2'd2: begin acc_dat[23:16] = acc_byte; acc_sel = 4'b0100; end
      default: begin acc_dat[31:24] = acc_byte; acc_sel = 4'b1000; end
    endcase
  end

  // Read data comes from the same lane as the outstanding address. A timed-out
  // read has no ack, so it yields zero.
  logic [7:0] rd_byte;
  always_comb begin
    rd_byte = 8'h00;
    if (wb_ack_i) begin
      case (wb_adr_q[1:0])
        2'd0:    rd_byte = wb_dat_i[7:0];
        2'd1:    rd_byte = wb_dat_i[15:8];
        2'd2:    rd_byte = wb_dat_i[23:16];
        default: rd_byte = wb_dat_i[31:24];
      endcase
    end
  end

  logic timeout;
  logic done;
  assign timeout = busy_q && !wb_ack_i && (wait_q == TW'(ACK_TIMEOUT - 1));
  assign done    = busy_q && (wb_ack_i || timeout);

  // Combinational so the producer can present its next byte during the idle
  // cycle that follows, where the continue/stop decision is taken.
  assign tx_ready_o = done && (state_q == TX_WR);

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= CFG_LCR1;
      busy_q      <= 1'b0;
      wait_q      <= '0;
      burst_q     <= '0;
      thre_q      <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_sel_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      lsr_q       <= '0;
    end else begin
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      if (!busy_q) begin
        // Idle cycle: either start the state's access or, in TX_WR with no
        // data or no burst budget left, fall back to polling.
        if (state_q == TX_WR && !(tx_valid_i && burst_q != '0)) begin
          state_q <= POLL;
        end else begin
          busy_q   <= 1'b1;
          wait_q   <= '0;
          wb_cyc_q <= 1'b1;
          wb_stb_q <= 1'b1;
          wb_adr_q <= acc_adr;
          wb_we_q  <= acc_we;
          wb_sel_q <= acc_sel;
          wb_dat_q <= acc_we ? acc_dat : 32'h0;
        end
      end else if (done) begin
        busy_q   <= 1'b0;
        wb_cyc_q <= 1'b0;
        wb_stb_q <= 1'b0;
        wb_adr_q <= '0;
        wb_we_q  <= 1'b0;
        wb_sel_q <= '0;
        wb_dat_q <= '0;
        if (timeout) begin
          err_q <= 1'b1;
        end
        case (state_q)
          CFG_LCR1: state_q <= CFG_DL1;
          CFG_DL1:  state_q <= CFG_DL2;
          CFG_DL2:  state_q <= CFG_LCR2;
          CFG_LCR2: state_q <= CFG_IER;
          CFG_IER: begin
            init_done_q <= 1'b1;
            state_q     <= POLL;
          end
          POLL: begin
            lsr_q  <= rd_byte;
            thre_q <= rd_byte[5];
            if (rd_byte[0] && !rx_valid_q) begin
              state_q <= RX_RD;
            end else if (rd_byte[5] && tx_valid_i) begin
              state_q <= TX_WR;
              burst_q <= BW'(TX_BURST);
            end else begin
              state_q <= POLL;
            end
          end
          RX_RD: begin
            rx_data_q  <= rd_byte;
            rx_valid_q <= 1'b1;
            // THRE from the same poll round still authorises a burst.
            if (thre_q && tx_valid_i) begin
              state_q <= TX_WR;
              burst_q <= BW'(TX_BURST);
            end else begin
              state_q <= POLL;
            end
          end
          TX_WR: begin
            burst_q <= burst_q - BW'(1);
          end
          default: state_q <= POLL;
        endcase
      end else begin
        wait_q <= wait_q + TW'(1);
      end
    end
  end

  assign wb_adr_o    = wb_adr_q;
  assign wb_dat_o    = wb_dat_q;
  assign wb_we_o     = wb_we_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_sel_o    = wb_sel_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;
  assign lsr_o       = lsr_q;

endmodule
